mem_bus_unit: RTL and testbench

//  - Memory bus sequencer between the CPU datapath address/store-data selects and the external 8-bit async SRAM.
//  - Accepts one byte access per request; inputs are the 16-bit address (from the address select) and the 8-bit store data (from the store select).
//  - Reads land in the MDRH/MDRL holding registers, which feed the ALU operand select and the address select.
//  - Single outstanding access; programmable wait states; write recovery cycle.

---
 rtl/mem_bus_unit_if.sv | 35 +++
 rtl/mem_bus_unit.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_unit_if.sv
// Bus bundle for mem_bus_unit: CPU-side request/response handshake plus the
// external 8-bit async SRAM pins. The "slave" modport is the sequencer's
// view. The "master" modport is the view of the surrounding datapath and SRAM.
interface mem_bus_unit_if;
    // request side
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [1:0]  req_dst;
    // completion and data holding registers
    logic        done;
    logic [7:0]  MDRH;
    logic [7:0]  MDRL;
    // SRAM side
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic        mem_we_n;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_dst, mem_rdata,
        output req_ready, done, MDRH, MDRL,
               mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_dst, mem_rdata,
        input  req_ready, done, MDRH, MDRL,
               mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
    );
endinterface

// File: rtl/mem_bus_unit.sv
// mem_bus_unit: single-outstanding byte access sequencer for an 8-bit async SRAM.
// IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> IDLE for reads, with an extra
// RECOVER cycle after writes. Read data lands in MDRH/MDRL according to req_dst.
// All SRAM strobes are registered, so they cannot glitch.
// Optional build macro MEM_BUS_RDY_EN adds a synchronous rdy input. While rdy
// is low, the last ACCESS cycle is stretched.
module mem_bus_unit #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic            Clk,
    input  logic            Reset_n,
`ifdef MEM_BUS_RDY_EN
    input  logic            rdy,
`endif
    mem_bus_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_RECOVER = 2'b10
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             we_r;
    logic [1:0]       dst_r;
    logic [15:0]      addr_r;
    logic [7:0]       wdata_r;
    logic [7:0]       mdrh_r, mdrl_r;
    logic             done_r, done_n;
    logic             ce_n_r, oe_n_r, we_n_r;
    logic             ce_n_n, oe_n_n, we_n_n;
    logic             accept;
    logic             capture;
    logic             rdy_ok;

`ifdef MEM_BUS_RDY_EN
    assign rdy_ok = rdy;
`else
    assign rdy_ok = 1'b1;
`endif

    assign accept = (state == ST_IDLE) && bus.req_valid;

    // next-state, counter and next-strobe decode; strobes are registered below
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ce_n_n  = 1'b1;
        oe_n_n  = 1'b1;
        we_n_n  = 1'b1;
        done_n  = 1'b0;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_n = ST_ACCESS;
                    cnt_n   = CNT_W'(WAIT_CYCLES);
                    ce_n_n  = 1'b0;
                    if (bus.req_we) begin
                        we_n_n = 1'b0;
                    end else begin
                        oe_n_n = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                if ((cnt == '0) && rdy_ok) begin
                    if (we_r) begin
                        state_n = ST_RECOVER;
                        ce_n_n  = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                        done_n  = 1'b1;
                        capture = 1'b1;
                    end
                end else begin
                    ce_n_n = 1'b0;
                    if (we_r) begin
                        we_n_n = 1'b0;
                    end else begin
                        oe_n_n = 1'b0;
                    end
                    if (cnt != '0) begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            ST_RECOVER: begin
                state_n = ST_IDLE;
                done_n  = 1'b1;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // state register, registered strobes and done pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ce_n_r <= 1'b1;
            oe_n_r <= 1'b1;
            we_n_r <= 1'b1;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ce_n_r <= ce_n_n;
            oe_n_r <= oe_n_n;
            we_n_r <= we_n_n;
            done_r <= done_n;
        end
    end

    // request fields are latched only at the accept edge and held until the next accept
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            we_r    <= 1'b0;
            dst_r   <= '0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (accept) begin
            we_r    <= bus.req_we;
            dst_r   <= bus.req_dst;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
        end
    end

    // read data capture into the holding registers at the edge leaving ACCESS
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mdrh_r <= '0;
            mdrl_r <= '0;
        end else if (capture) begin
            case (dst_r)
                2'b00: mdrl_r <= bus.mem_rdata;
                2'b01: mdrh_r <= bus.mem_rdata;
                2'b10: begin
                    mdrl_r <= bus.mem_rdata;
                    mdrh_r <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.done      = done_r;
    assign bus.MDRH      = mdrh_r;
    assign bus.MDRL      = mdrl_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.mem_ce_n  = ce_n_r;
    assign bus.mem_oe_n  = oe_n_r;
    assign bus.mem_we_n  = we_n_r;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed self-checking bench for mem_bus_unit (WAIT_CYCLES=1).
// Inputs are driven on the falling edge, and outputs are sampled there too.
module tb_mem_bus_unit;

    logic Clk;
    logic Reset_n;
`ifdef MEM_BUS_RDY_EN
    logic rdy;
`endif
    int tests_run;
    int tests_failed;

    mem_bus_unit_if bus ();

    mem_bus_unit #(
        .WAIT_CYCLES (1),
        .CNT_W       (4)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
`ifdef MEM_BUS_RDY_EN
        .rdy     (rdy),
`endif
        .bus     (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // drive a request at a falling edge, let it be accepted, drop req_valid
    task automatic issue(input logic we, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [1:0] dst);
        @(negedge Clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_dst   = dst;
        @(posedge Clk);
        @(negedge Clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        tests_run++;
        if ({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n} !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_strobes got=%b exp=111", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n});
        end
        tests_run++;
        if ({bus.MDRH, bus.MDRL, bus.mem_addr, bus.mem_wdata, bus.done} !== 41'd0) begin
            tests_failed++;
            $display("FAIL reset_regs got MDRH=%h MDRL=%h addr=%h wdata=%h done=%b exp all 0",
                     bus.MDRH, bus.MDRL, bus.mem_addr, bus.mem_wdata, bus.done);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready got=%b exp=1", bus.req_ready);
        end
    endtask

    task automatic test_read();
        int k;
        int oe_low;
        // dst=01 first so MDRH holds a known nonzero value
        bus.mem_rdata = 8'h5A;
        issue(1'b0, 16'h0042, 8'h00, 2'b01);
        k = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            @(negedge Clk);
            k++;
        end
        tests_run++;
        if (bus.MDRH !== 8'h5A || bus.MDRL !== 8'h00) begin
            tests_failed++;
            $display("FAIL read_dst01 got MDRH=%h MDRL=%h exp 5a 00", bus.MDRH, bus.MDRL);
        end
        bus.mem_rdata = 8'hA5;
        issue(1'b0, 16'h1234, 8'h00, 2'b00);
        tests_run++;
        if (bus.mem_addr !== 16'h1234 || bus.mem_ce_n !== 1'b0 || bus.mem_we_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_bus got addr=%h ce_n=%b we_n=%b exp 1234 0 1",
                     bus.mem_addr, bus.mem_ce_n, bus.mem_we_n);
        end
        k = 0;
        oe_low = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            if (bus.mem_oe_n === 1'b0) oe_low++;
            @(negedge Clk);
            k++;
        end
        tests_run++;
        if (k !== 2) begin
            tests_failed++;
            $display("FAIL read_latency got=%0d exp=2", k);
        end
        tests_run++;
        if (oe_low !== 2 || bus.mem_oe_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_oe_width got=%0d oe_n_now=%b exp 2 1", oe_low, bus.mem_oe_n);
        end
        tests_run++;
        if (bus.MDRL !== 8'hA5 || bus.MDRH !== 8'h5A) begin
            tests_failed++;
            $display("FAIL read_mdr got MDRH=%h MDRL=%h exp 5a a5", bus.MDRH, bus.MDRL);
        end
        @(negedge Clk);
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_done_pulse got=%b exp=0", bus.done);
        end
    endtask

    task automatic test_write();
        int k;
        int we_low;
        int recov;
        int bad_hold;
        int oe_low;
        bus.mem_rdata = 8'hEE;
        issue(1'b1, 16'h01FF, 8'h3C, 2'b00);
        k = 0;
        we_low = 0;
        recov = 0;
        bad_hold = 0;
        oe_low = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            if (bus.mem_we_n === 1'b0 && bus.mem_ce_n === 1'b0) we_low++;
            if (bus.mem_we_n === 1'b1 && bus.mem_ce_n === 1'b0) recov++;
            if (bus.mem_oe_n !== 1'b1) oe_low++;
            if (bus.mem_addr !== 16'h01FF || bus.mem_wdata !== 8'h3C) bad_hold++;
            @(negedge Clk);
            k++;
        end
        tests_run++;
        if (k !== 3) begin
            tests_failed++;
            $display("FAIL write_latency got=%0d exp=3", k);
        end
        tests_run++;
        if (we_low !== 2 || recov !== 1 || oe_low !== 0) begin
            tests_failed++;
            $display("FAIL write_strobes got we_low=%0d recover=%0d oe_low=%0d exp 2 1 0",
                     we_low, recov, oe_low);
        end
        tests_run++;
        if (bad_hold !== 0) begin
            tests_failed++;
            $display("FAIL write_hold got bad_cycles=%0d exp=0", bad_hold);
        end
        tests_run++;
        if (bus.MDRH !== 8'h5A || bus.MDRL !== 8'hA5 || bus.mem_ce_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_idle got MDRH=%h MDRL=%h ce_n=%b exp 5a a5 1",
                     bus.MDRH, bus.MDRL, bus.mem_ce_n);
        end
        @(negedge Clk);
        tests_run++;
        if (bus.mem_addr !== 16'h01FF || bus.mem_wdata !== 8'h3C) begin
            tests_failed++;
            $display("FAIL write_idle_hold got addr=%h wdata=%h exp 01ff 3c", bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        bus.mem_rdata = 8'h44;
        issue(1'b0, 16'h0010, 8'h00, 2'b10);
        k = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            @(negedge Clk);
            k++;
        end
        tests_run++;
        if (bus.MDRL !== 8'h44 || bus.MDRH !== 8'h00) begin
            tests_failed++;
            $display("FAIL b2b_first got MDRH=%h MDRL=%h exp 00 44", bus.MDRH, bus.MDRL);
        end
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready_in_done got=%b exp=1", bus.req_ready);
        end
        // present the next request in the done cycle itself
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0011;
        bus.req_dst   = 2'b01;
        bus.mem_rdata = 8'h80;
        @(posedge Clk);
        @(negedge Clk);
        bus.req_valid = 1'b0;
        tests_run++;
        if (bus.req_ready !== 1'b0 || bus.mem_oe_n !== 1'b0 || bus.mem_addr !== 16'h0011) begin
            tests_failed++;
            $display("FAIL b2b_no_dead_cycle got ready=%b oe_n=%b addr=%h exp 0 0 0011",
                     bus.req_ready, bus.mem_oe_n, bus.mem_addr);
        end
        k = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            @(negedge Clk);
            k++;
        end
        tests_run++;
        if (k !== 2 || bus.MDRH !== 8'h80 || bus.MDRL !== 8'h44) begin
            tests_failed++;
            $display("FAIL b2b_second got lat=%0d MDRH=%h MDRL=%h exp 2 80 44", k, bus.MDRH, bus.MDRL);
        end
        // hold req_valid through a whole busy period: exactly one access
        @(negedge Clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h0020;
        bus.req_dst   = 2'b00;
        bus.mem_rdata = 8'h11;
        @(posedge Clk);
        @(negedge Clk);
        k = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            if (bus.req_ready !== 1'b0) k = 100;
            @(negedge Clk);
            k++;
        end
        bus.req_valid = 1'b0;
        tests_run++;
        if (k !== 2) begin
            tests_failed++;
            $display("FAIL held_valid_busy got=%0d exp=2", k);
        end
        @(negedge Clk);
        tests_run++;
        if (bus.done !== 1'b0 || bus.mem_oe_n !== 1'b1 || bus.req_ready !== 1'b1 || bus.MDRL !== 8'h11) begin
            tests_failed++;
            $display("FAIL held_valid_single got done=%b oe_n=%b ready=%b MDRL=%h exp 0 1 1 11",
                     bus.done, bus.mem_oe_n, bus.req_ready, bus.MDRL);
        end
    endtask

    task automatic test_dummy_read();
        int k;
        int oe_low;
        bus.mem_rdata = 8'hFF;
        issue(1'b0, 16'h0030, 8'h00, 2'b11);
        k = 0;
        oe_low = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            if (bus.mem_oe_n === 1'b0) oe_low++;
            @(negedge Clk);
            k++;
        end
        tests_run++;
        if (k !== 2 || oe_low !== 2) begin
            tests_failed++;
            $display("FAIL dummy_cycle got lat=%0d oe_low=%0d exp 2 2", k, oe_low);
        end
        tests_run++;
        if (bus.MDRH !== 8'h80 || bus.MDRL !== 8'h11) begin
            tests_failed++;
            $display("FAIL dummy_mdr got MDRH=%h MDRL=%h exp 80 11", bus.MDRH, bus.MDRL);
        end
    endtask

    task automatic test_mid_access_reset();
        bus.mem_rdata = 8'h77;
        issue(1'b0, 16'h4321, 8'h00, 2'b00);
        tests_run++;
        if (bus.mem_oe_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_pre got oe_n=%b exp=0", bus.mem_oe_n);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n} !== 3'b111 || bus.MDRH !== 8'h00 || bus.MDRL !== 8'h00) begin
            tests_failed++;
            $display("FAIL midreset_async got strobes=%b MDRH=%h MDRL=%h exp 111 00 00",
                     {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, bus.MDRH, bus.MDRL);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        tests_run++;
        if (bus.req_ready !== 1'b1 || bus.mem_addr !== 16'h0000 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_release got ready=%b addr=%h done=%b exp 1 0000 0",
                     bus.req_ready, bus.mem_addr, bus.done);
        end
    endtask

`ifdef MEM_BUS_RDY_EN
    task automatic test_rdy();
        int k;
        int oe_low;
        rdy = 1'b0;
        bus.mem_rdata = 8'h5C;
        issue(1'b0, 16'h0050, 8'h00, 2'b00);
        k = 0;
        oe_low = 0;
        while (bus.done !== 1'b1 && k < 20) begin
            if (bus.mem_oe_n === 1'b0) oe_low++;
            if (k == 4) rdy = 1'b1;
            @(negedge Clk);
            k++;
        end
        rdy = 1'b1;
        tests_run++;
        if (k !== 5 || oe_low !== 5) begin
            tests_failed++;
            $display("FAIL rdy_stretch got lat=%0d oe_low=%0d exp 5 5", k, oe_low);
        end
        tests_run++;
        if (bus.MDRL !== 8'h5C) begin
            tests_failed++;
            $display("FAIL rdy_capture got MDRL=%h exp 5c", bus.MDRL);
        end
    endtask
`endif

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        Reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_dst   = '0;
        bus.mem_rdata = '0;
`ifdef MEM_BUS_RDY_EN
        rdy = 1'b1;
`endif
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_dummy_read();
        test_mid_access_reset();
`ifdef MEM_BUS_RDY_EN
        test_rdy();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
